// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter with data select:
// requester count, select width, FSM state encodings and a one-hot helper.
package mux_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // One-hot vector with element idx set; element 0 is the MSB.
    function automatic logic [0:NUM_REQ-1] onehot_f(input logic [SEL_W-1:0] idx);
        logic [0:NUM_REQ-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_16_1.sv
// 16:1 single-bit data select. Element 0 of in is the MSB.
module mux_16_1
    import mux_arb_pkg::*;
(
    input  logic [0:NUM_REQ-1] in,
    input  logic [SEL_W-1:0]   sel,
    output logic               out
);

    // Pure combinational pick of the selected requester's data bit.
    always_comb begin
        out = in[sel];
    end

endmodule

// File: rtl/rr_mux_arbiter_16.sv
// Round-robin arbiter over 16 requesters with a registered one-hot grant,
// registered select index and a 1-cycle-latency copy of the granted
// requester's data bit. Every grant is followed by a one-cycle GAP.
//
// Build option: define ARB_TIMEOUT_EN to cap each grant at HOLD cycles.
// Without it a grant lasts until the granted requester drops its request
// and the tenure counter is not built.
module rr_mux_arbiter_16
    import mux_arb_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:NUM_REQ-1] req,
    input  logic [0:NUM_REQ-1] in,
    output logic [0:NUM_REQ-1] grant,
    output logic [0:SEL_W-1]   sel,
    output logic               valid,
    output logic               out
);

    // HOLD must fit the 4-bit tenure counter and be at least one cycle.
    if (HOLD < 1 || HOLD > 15) begin : g_hold_range_err
        $error("rr_mux_arbiter_16: HOLD=%0d outside 1..15", HOLD);
    end

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic                w_load;
    logic [SEL_W-1:0]    w_winner;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [0:NUM_REQ-1]  r_grant;
    logic                r_out;
    logic                w_mux_out;

`ifdef ARB_TIMEOUT_EN
    localparam logic [SEL_W-1:0] HOLD_CNT = SEL_W'(HOLD);
    logic [SEL_W-1:0]    r_cnt;
`endif

    // Data-select of the currently selected requester's input bit.
    mux_16_1 u_mux (
        .in  (in),
        .sel (r_sel),
        .out (w_mux_out)
    );

    // Round-robin search: first asserted request from ptr+1 upward with
    // wrap. Scanning offsets high-to-low lets the nearest hit win; offset 16
    // wraps to ptr itself, so a lone requester at ptr is found last.
    always_comb begin
        w_winner = r_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[r_ptr + SEL_W'(k)]) begin
                w_winner = r_ptr + SEL_W'(k);
            end
        end
    end

    // Next-state logic; w_load marks an edge that starts a new grant.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_next = GRANT;
                    w_load = 1'b1;
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (!req[r_sel] || (r_cnt == HOLD_CNT)) begin
                    w_next = GAP;
                end
`else
                if (!req[r_sel]) begin
                    w_next = GAP;
                end
`endif
            end
            GAP: begin
                if (|req) begin
                    w_next = GRANT;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, select, round-robin pointer and registered data output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '1;
            r_out   <= 1'b0;
        end else begin
            if (w_load) begin
                r_sel   <= w_winner;
                r_grant <= onehot_f(w_winner);
            end else if (w_next != GRANT) begin
                r_grant <= '0;
            end
            if ((r_state == GRANT) && (w_next == GAP)) begin
                r_ptr <= r_sel;
            end
            // Data only passes while a grant continues; forced low on the
            // entry cycle, during GAP and in IDLE.
            r_out <= ((r_state == GRANT) && (w_next == GRANT)) ? w_mux_out : 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Tenure counter: 1 on the grant's first cycle, +1 per extra cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= SEL_W'(1);
        end else if ((r_state == GRANT) && (w_next == GRANT)) begin
            r_cnt <= r_cnt + SEL_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`endif

    assign grant = r_grant;
    assign sel   = r_sel;
    assign valid = |r_grant;
    assign out   = r_out;

endmodule

// File: tb/tb_rr_mux_arbiter_16.sv
// Directed bench for rr_mux_arbiter_16: a cycle-by-cycle vector table plus
// hand-written sequences for long grants (or rotation with ARB_TIMEOUT_EN).
module tb_rr_mux_arbiter_16;

    localparam int TB_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:15] req;
    logic [0:15] din;
    logic [0:15] grant;
    logic [0:3]  sel;
    logic        valid;
    logic        dout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_16 #(.HOLD(TB_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .in    (din),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .out   (dout)
    );

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] din;
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        valid;
        logic        out;
    } vec_t;

    vec_t tbl[31];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] eg, input logic [3:0] es,
                                 input logic ev, input logic eo);
        check({tag, ".grant"}, grant, eg);
        check({tag, ".sel"}, 16'(sel), 16'(es));
        check({tag, ".valid"}, 16'(valid), 16'(ev));
        check({tag, ".out"}, 16'(dout), 16'(eo));
        check({tag, ".onehot"}, 16'($onehot0(grant)), 16'd1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        din   = '0;

        //             rst   req       din       grant     sel    valid out
        tbl[0]  = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h8000, 4'd0,  1'b1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0100, 16'h0000, 16'h0100, 4'd7,  1'b1, 1'b0};
        tbl[6]  = '{1'b0, 16'h0100, 16'h0100, 16'h0100, 4'd7,  1'b1, 1'b1};
        tbl[7]  = '{1'b0, 16'h0100, 16'h0000, 16'h0100, 4'd7,  1'b1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd7,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd7,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h0100, 16'h0000, 16'h0100, 4'd7,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'h0100, 16'h0000, 16'h0100, 4'd7,  1'b1, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd7,  1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0400, 16'h0400, 16'h0400, 4'd5,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 16'hFFFF, 16'h0400, 16'h0400, 4'd5,  1'b1, 1'b1};
        tbl[15] = '{1'b0, 16'h0401, 16'h0000, 16'h0400, 4'd5,  1'b1, 1'b0};
        tbl[16] = '{1'b0, 16'h0001, 16'h0400, 16'h0000, 4'd5,  1'b0, 1'b0};
        tbl[17] = '{1'b0, 16'h0001, 16'h0000, 16'h0001, 4'd15, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 16'h0001, 16'h0000, 16'h0001, 4'd15, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 16'h0002, 16'h0000, 16'h0000, 4'd15, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 16'h0002, 16'h0000, 16'h0002, 4'd14, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd14, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 16'h8002, 16'h0000, 16'h8000, 4'd0,  1'b1, 1'b0};
        tbl[23] = '{1'b0, 16'h0002, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[24] = '{1'b0, 16'h0002, 16'h0000, 16'h0002, 4'd14, 1'b1, 1'b0};
        tbl[25] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd14, 1'b0, 1'b0};
        tbl[26] = '{1'b0, 16'h1000, 16'h1000, 16'h1000, 4'd3,  1'b1, 1'b0};
        tbl[27] = '{1'b1, 16'h1000, 16'h1000, 16'h0000, 4'd0,  1'b0, 1'b0};
        tbl[28] = '{1'b0, 16'h1001, 16'h0000, 16'h1000, 4'd3,  1'b1, 1'b0};
        tbl[29] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd3,  1'b0, 1'b0};
        tbl[30] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd3,  1'b0, 1'b0};

        for (int i = 0; i < 31; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            din   = tbl[i].din;
            tick();
            check_outputs($sformatf("row%0d", i), tbl[i].grant, tbl[i].sel,
                          tbl[i].valid, tbl[i].out);
        end

        // Fresh reset with every requester active.
        reset = 1'b1;
        req   = 16'hFFFF;
        din   = 16'h8000;
        tick();
        tick();
        check_outputs("rst2", 16'h0000, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Rotation: each requester holds TB_HOLD cycles, then one GAP cycle.
        din = 16'h0000;
        for (int r = 0; r <= 16; r++) begin
            for (int c = 0; c < TB_HOLD; c++) begin
                tick();
                check_outputs($sformatf("rot%0d_c%0d", r, c), 16'h8000 >> (r % 16),
                              4'(r % 16), 1'b1, 1'b0);
            end
            tick();
            check_outputs($sformatf("rot%0d_gap", r), 16'h0000, 4'(r % 16), 1'b0, 1'b0);
        end
`else
        // No tenure limit: requester 0 keeps the grant while it requests.
        tick();
        check_outputs("hold_first", 16'h8000, 4'd0, 1'b1, 1'b0);
        for (int c = 0; c < 19; c++) begin
            tick();
            check_outputs($sformatf("hold%0d", c), 16'h8000, 4'd0, 1'b1, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
